// File: rtl/vend_ctrl_multi.sv
// rtl/vend_ctrl_multi.sv - multi-product vending controller with credit, per-product stock and change return
module vend_ctrl_multi #(
  parameter int                           NUM_PROD   = 8,
  parameter int                           SEL_W      = 3,
  parameter int                           CREDIT_W   = 8,
  parameter int                           MAX_CREDIT = 200,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES     = {8'd15, 8'd15, 8'd15, 8'd15,
                                                        8'd30, 8'd20, 8'd7,  8'd10},
  parameter int                           STOCK_W    = 4,
  parameter int                           INIT_STOCK = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                select_valid,
  input  logic [SEL_W-1:0]    select,
  input  logic                cancel,
  input  logic                restock,
  input  logic [SEL_W-1:0]    restock_sel,
  output logic                dispense,
  output logic [SEL_W-1:0]    dispense_id,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change,
  output logic                refund,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                sold_out,
  output logic                insufficient
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_RETURN = 2'd3
  } state_e;

  localparam logic [CREDIT_W:0]  MAX_C     = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;
  localparam logic [STOCK_W-1:0] INIT_S    = STOCK_W'(INIT_STOCK);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CREDIT_W-1:0] residual_q, residual_d;
  logic                refund_q, refund_d;
  logic [STOCK_W-1:0]  stock_q [NUM_PROD];
  logic [STOCK_W-1:0]  stock_d [NUM_PROD];
  logic                coin_rej_q, coin_rej_d;
  logic                sold_q, sold_d;
  logic                insuf_q, insuf_d;

  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W-1:0] vend_price;
  logic [STOCK_W-1:0]  sel_stock;
  logic                sel_ok;
  logic [CREDIT_W:0]   coin_sum;

  // Out-of-range indices match no entry, so they read as price 0 / stock 0.
  always_comb begin
    sel_price  = '0;
    sel_stock  = '0;
    vend_price = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (32'(select) == i) begin
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_stock = stock_q[i];
      end
      if (32'(sel_q) == i) begin
        vend_price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  assign sel_ok   = (32'(select) < NUM_PROD);
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    sel_d      = sel_q;
    residual_d = residual_q;
    refund_d   = refund_q;
    stock_d    = stock_q;
    coin_rej_d = 1'b0;
    sold_d     = 1'b0;
    insuf_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        for (int i = 0; i < NUM_PROD; i++) begin
          if (restock && (32'(restock_sel) == i) && (stock_q[i] != STOCK_MAX)) begin
            stock_d[i] = stock_q[i] + STOCK_W'(1);
          end
        end
        if (coin_valid && (coin_value != '0)) begin
          if ({1'b0, coin_value} > MAX_C) begin
            coin_rej_d = 1'b1;
          end else begin
            credit_d = coin_value;
            state_d  = ST_CREDIT;
          end
        end
      end

      // Priority: cancel, then select, then coin; a coin that loses is rejected.
      ST_CREDIT: begin
        if (cancel) begin
          coin_rej_d = coin_valid;
          residual_d = credit_q;
          refund_d   = 1'b1;
          state_d    = ST_RETURN;
        end else if (select_valid) begin
          coin_rej_d = coin_valid;
          if (!sel_ok || (sel_stock == '0)) begin
            sold_d = 1'b1;
          end else if (credit_q < sel_price) begin
            insuf_d = 1'b1;
          end else begin
            sel_d   = select;
            state_d = ST_VEND;
          end
        end else if (coin_valid) begin
          if (coin_sum > MAX_C) begin
            coin_rej_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
          end
        end
      end

      ST_VEND: begin
        coin_rej_d = coin_valid;
        for (int i = 0; i < NUM_PROD; i++) begin
          if (32'(sel_q) == i) begin
            stock_d[i] = stock_q[i] - STOCK_W'(1);
          end
        end
        residual_d = credit_q - vend_price;
        refund_d   = 1'b0;
        state_d    = ST_RETURN;
      end

      ST_RETURN: begin
        coin_rej_d = coin_valid;
        credit_d   = '0;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      sel_q      <= '0;
      residual_q <= '0;
      refund_q   <= 1'b0;
      coin_rej_q <= 1'b0;
      sold_q     <= 1'b0;
      insuf_q    <= 1'b0;
      for (int i = 0; i < NUM_PROD; i++) begin
        stock_q[i] <= INIT_S;
      end
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      sel_q      <= sel_d;
      residual_q <= residual_d;
      refund_q   <= refund_d;
      coin_rej_q <= coin_rej_d;
      sold_q     <= sold_d;
      insuf_q    <= insuf_d;
      stock_q    <= stock_d;
    end
  end

  // Strobes come straight from state, so reset clears them asynchronously.
  assign dispense     = (state_q == ST_VEND);
  assign dispense_id  = dispense ? sel_q : '0;
  assign change_valid = (state_q == ST_RETURN);
  assign change       = change_valid ? residual_q : '0;
  assign refund       = change_valid & refund_q;
  assign busy         = dispense | change_valid;
  assign credit       = credit_q;
  assign coin_reject  = coin_rej_q;
  assign sold_out     = sold_q;
  assign insufficient = insuf_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb/tb_vend_ctrl_multi.sv - scoreboard bench for vend_ctrl_multi with a transaction-level reference model
module tb_vend_ctrl_multi;

  localparam int K_DISP = 0;
  localparam int K_CHG  = 1;
  localparam int K_REJ  = 2;
  localparam int K_SOLD = 3;
  localparam int K_INS  = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       coin_valid;
  logic [7:0] coin_value;
  logic       select_valid;
  logic [2:0] select;
  logic       cancel;
  logic       restock;
  logic [2:0] restock_sel;
  logic       dispense;
  logic [2:0] dispense_id;
  logic       change_valid;
  logic [7:0] change;
  logic       refund;
  logic [7:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       sold_out;
  logic       insufficient;

  always #5 clk = ~clk;

  vend_ctrl_multi dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .select_valid (select_valid),
    .select       (select),
    .cancel       (cancel),
    .restock      (restock),
    .restock_sel  (restock_sel),
    .dispense     (dispense),
    .dispense_id  (dispense_id),
    .change_valid (change_valid),
    .change       (change),
    .refund       (refund),
    .credit       (credit),
    .busy         (busy),
    .coin_reject  (coin_reject),
    .sold_out     (sold_out),
    .insufficient (insufficient)
  );

  typedef struct {
    int kind;
    int val;
    int flag;
    int cyc;
  } ev_t;

  ev_t   exq[$];
  int    cyc = 0;
  int    checks = 0;
  int    passes = 0;
  string kname[5] = '{"dispense", "change", "coin_reject", "sold_out", "insufficient"};

  // Reference model: money in the machine, whether a session is open, busy cycles left.
  int m_credit;
  int m_sess;
  int m_busy;
  int m_stock[8];
  int price[8] = '{10, 7, 20, 30, 15, 15, 15, 15};
  int coin_set[8] = '{0, 1, 5, 10, 20, 25, 50, 100};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(int kind, int val, int flag, int at);
    ev_t e;
    e.kind = kind; e.val = val; e.flag = flag; e.cyc = at;
    exq.push_back(e);
  endtask

  task automatic model_reset();
    m_credit = 0; m_sess = 0; m_busy = 0;
    foreach (m_stock[i]) m_stock[i] = 5;
  endtask

  task automatic match(int kind, int val, int flag);
    int idx = -1;
    for (int i = 0; i < exq.size(); i++) begin
      if (idx < 0 && exq[i].kind == kind && exq[i].cyc == cyc) idx = i;
    end
    checks++;
    if (idx < 0) begin
      $display("FAIL unexpected %s: got val %0d flag %0d, expected no event (cycle %0d)",
               kname[kind], val, flag, cyc);
    end else begin
      if (exq[idx].val == val && exq[idx].flag == flag) passes++;
      else $display("FAIL %s: got val %0d flag %0d, expected val %0d flag %0d (cycle %0d)",
                    kname[kind], val, flag, exq[idx].val, exq[idx].flag, cyc);
      exq.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (dispense) match(K_DISP, int'(dispense_id), 0);
      else check("dispense_id_idle", int'(dispense_id), 0);
      if (change_valid) match(K_CHG, int'(change), int'(refund));
      else check("change_idle", int'(change), 0);
      if (coin_reject)  match(K_REJ, 0, 0);
      if (sold_out)     match(K_SOLD, 0, 0);
      if (insufficient) match(K_INS, 0, 0);
      for (int i = exq.size() - 1; i >= 0; i--) begin
        if (exq[i].cyc <= cyc) begin
          checks++;
          $display("FAIL missing %s: got no event, expected val %0d flag %0d (cycle %0d)",
                   kname[exq[i].kind], exq[i].val, exq[i].flag, exq[i].cyc);
          exq.delete(i);
        end
      end
    end
  end

  task automatic drive(bit cv, int cval, bit sv, int s, bit cn, bit rs, int rsel);
    int c;
    @(negedge clk);
    if (m_busy == 0) check("credit", int'(credit), m_credit);
    check("busy", int'(busy), (m_busy > 0) ? 1 : 0);
    coin_valid = cv; coin_value = 8'(cval);
    select_valid = sv; select = 3'(s);
    cancel = cn; restock = rs; restock_sel = 3'(rsel);
    c = cyc;
    if (m_busy > 0) begin
      if (cv) push(K_REJ, 0, 0, c + 1);
      m_busy--;
    end else if (!m_sess) begin
      if (rs && rsel < 8 && m_stock[rsel] < 15) m_stock[rsel]++;
      if (cv && cval != 0) begin
        if (cval > 200) push(K_REJ, 0, 0, c + 1);
        else begin m_credit = cval; m_sess = 1; end
      end
    end else if (cn) begin
      if (cv) push(K_REJ, 0, 0, c + 1);
      push(K_CHG, m_credit, 1, c + 1);
      m_credit = 0; m_sess = 0; m_busy = 1;
    end else if (sv) begin
      if (cv) push(K_REJ, 0, 0, c + 1);
      if (s >= 8 || m_stock[s] == 0) push(K_SOLD, 0, 0, c + 1);
      else if (m_credit < price[s]) push(K_INS, 0, 0, c + 1);
      else begin
        push(K_DISP, s, 0, c + 1);
        push(K_CHG, m_credit - price[s], 0, c + 2);
        m_stock[s]--;
        m_credit = 0; m_sess = 0; m_busy = 2;
      end
    end else if (cv) begin
      if (m_credit + cval > 200) push(K_REJ, 0, 0, c + 1);
      else m_credit += cval;
    end
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic coin(int v);      drive(1, v, 0, 0, 0, 0, 0); endtask
  task automatic buy(int s);       drive(0, 0, 1, s, 0, 0, 0); endtask
  task automatic cancel_op();      drive(0, 0, 0, 0, 1, 0, 0); endtask
  task automatic restock_op(int s); drive(0, 0, 0, 0, 0, 1, s); endtask

  task automatic reset_mid();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    coin_valid = 0; select_valid = 0; cancel = 0; restock = 0;
    #1;
    check("rst_dispense", int'(dispense), 0);
    check("rst_change_valid", int'(change_valid), 0);
    check("rst_change", int'(change), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_credit", int'(credit), 0);
    exq.delete();
    model_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    coin_valid = 0; coin_value = 0; select_valid = 0; select = 0;
    cancel = 0; restock = 0; restock_sel = 0;
    model_reset();
    #1;
    check("reset_dispense", int'(dispense), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_credit", int'(credit), 0);
    check("reset_change_valid", int'(change_valid), 0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;

    // exact payment, change with remainder, insufficient then top-up
    coin(10); buy(0); idle(3);
    coin(10); buy(1); idle(3);
    coin(10); buy(2); coin(10); buy(2); idle(3);
    // cancel with refund; cancel beats select and coin in the same cycle
    coin(20); coin(10); cancel_op(); idle(2);
    coin(10); drive(1, 5, 1, 0, 1, 0, 0); idle(2);
    // drain product 3, sold out, restock, buy again
    repeat (5) begin coin(20); coin(10); buy(3); idle(2); end
    coin(20); coin(10); buy(3); cancel_op(); idle(2);
    restock_op(3); coin(20); coin(10); buy(3); idle(3);
    // credit ceiling, then reset while vending
    coin(100); coin(95); coin(10); idle(1);
    buy(0);
    reset_mid();
    idle(2);

    // random phase: any input combination each cycle
    for (int n = 0; n < 800; n++) begin
      drive(($urandom_range(0, 9) < 4), coin_set[$urandom_range(0, 7)],
            ($urandom_range(0, 9) < 2), $urandom_range(0, 7),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) == 0), $urandom_range(0, 7));
    end
    idle(5);
    check("queue_drained", exq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_multi.md
VEND_CTRL_MULTI -- requirements
Module: vend_ctrl_multi

Interface
REQ-001 SHALL have parameter NUM_PROD, default 8, number of selectable products.
REQ-002 SHALL have parameter SEL_W, default 3, select width, with 2^SEL_W >= NUM_PROD.
REQ-003 SHALL have parameter CREDIT_W, default 8, width of credit, coin and change values.
REQ-004 SHALL have parameter MAX_CREDIT, default 200, credit ceiling, at most 2^CREDIT_W-1.
REQ-005 SHALL have parameter PRICES, default prices (product0..7) 10, 7, 20, 30, 15, 15, 15, 15, packed NUM_PROD*CREDIT_W vector, product i in bits [i*CREDIT_W +: CREDIT_W].
REQ-006 SHALL have parameters STOCK_W, default 4, and INIT_STOCK, default 5, per-product stock counter width and reset value.
REQ-007 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-008 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have ports coin_valid, input, 1 and coin_value, input, CREDIT_W: one coin per cycle while coin_valid=1.
REQ-010 SHALL have ports select_valid, input, 1 and select, input, SEL_W: product request.
REQ-011 SHALL have port cancel, input, 1, abort and return credit.
REQ-012 SHALL have ports restock, input, 1 and restock_sel, input, SEL_W: add one unit to product.
REQ-013 SHALL have outputs dispense (1) and dispense_id (SEL_W), one-cycle vend pulse and product index.
REQ-014 SHALL have outputs change_valid (1), change (CREDIT_W) and refund (1): money-return pulse, amount, and a flag marking a cancel return.
REQ-015 SHALL have outputs credit (CREDIT_W), busy (1), coin_reject (1), sold_out (1) and insufficient (1); the last three are one-cycle pulses.

Function
REQ-016 SHALL implement FSM states IDLE, CREDIT, VEND, RETURN; busy=1 in VEND and RETURN only.
REQ-017 IDLE: coin_valid with coin_value>0 SHALL load credit=coin_value, go to CREDIT; zero-value coin ignored.
REQ-018 CREDIT: accepted coin SHALL add to credit; if credit+coin_value > MAX_CREDIT, coin_reject pulses and credit stays unchanged.
REQ-019 CREDIT, select_valid: select >= NUM_PROD or stock[select]==0 SHALL pulse sold_out and stay; credit < price pulses insufficient and stays; otherwise latch select and go to VEND.
REQ-020 VEND (exactly one cycle): dispense=1, dispense_id=latched select, stock decremented, residual=credit-price latched; next state RETURN with refund=0.
REQ-021 CREDIT, cancel: next state RETURN with residual=credit, refund=1.
REQ-022 RETURN (exactly one cycle): change_valid=1, change=residual (0 allowed on exact payment), refund per REQ-020/021; credit cleared; next state IDLE.
REQ-023 Latency: select_valid sampled at edge N -> dispense high in cycle N+1, change_valid in cycle N+2; cancel at N -> change_valid in N+1.
REQ-024 Same-cycle priority in CREDIT: cancel > select_valid > coin_valid; lower-priority coin SHALL pulse coin_reject, be lost from credit, and not be included in change.
REQ-025 coin_valid in VEND or RETURN SHALL pulse coin_reject; credit unaffected.
REQ-026 cancel or select_valid in IDLE SHALL be ignored (no pulses).
REQ-027 restock SHALL be honoured only in IDLE with restock_sel < NUM_PROD; stock saturates at 2^STOCK_W-1; ignored otherwise.
REQ-028 change, dispense_id SHALL hold 0 when their valid strobe is low.

Reset
REQ-029 reset_n=0 SHALL asynchronously force IDLE, credit=0, all pulses/strobes/change/dispense_id=0, busy=0, every stock=INIT_STOCK.
REQ-030 Reset asserted mid-VEND or mid-RETURN SHALL abort without dispense or change; inserted credit is forfeited.

Verification
REQ-031 Coin 10, select 0 -> dispense=1 id=0 at N+1; change_valid=1 change=0 refund=0 at N+2; credit=0.
REQ-032 Coin 10, select 1 -> dispense id=1; change=3, refund=0; stock[1] 5->4.
REQ-033 Coin 10, select 2 -> insufficient pulse, no dispense, credit=10; coin 10, select 2 -> dispense, change=0.
REQ-034 Coins 20+10, cancel -> change_valid=1, change=30, refund=1, no dispense; simultaneous cancel+select+coin -> refund path, coin_reject=1.
REQ-035 Six buys of product 3 at 30 each -> sixth gives sold_out, no dispense; restock 3 in IDLE -> next buy dispenses.
REQ-036 Credit 195, coin 10 -> coin_reject, credit=195; reset_n low during VEND -> outputs 0, state IDLE, stock reset to 5.
